pipeline_control: RTL and testbench

- Central sequencer for the 5-stage MIPS pipeline.
- Generates per-latch enables and flushes, the PC enable, and the imem/dmem request strobes from ihit/dhit.
- Handles load-use hazards, taken-branch/jump flushes, and the halt handshake to the cache interface.
- Sits beside the datapath in the hazard-detection slot. It is the only block that freezes or bubbles the fetch/decode/execute/mem register banks.

---
 rtl/pipeline_control.sv | 111 +++++++++++
 tb/tb_pipeline_control.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Pipeline sequencer: latch enables/flushes, PC enable and memory strobes
// from ihit/dhit, with load-use stalls, taken-branch flushes and sticky halt.
module pipeline_control #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       dec_rs,
   input  logic [4:0]       dec_rt,
   input  logic             dec_uses_rt,
   input  logic             ex_dREN,
   input  logic [4:0]       ex_wsel,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             mem_branch_taken,
   input  logic             mem_halt,
   output logic             pc_en,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             execute_en,
   output logic             mem_en,
   output logic             fetch_flush,
   output logic             decode_flush,
   output logic             execute_flush,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             halt,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

   state_e           state_q, state_d;
   logic             served_q, served_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic run, memreq, advance, hazard, stall_inc;

   // Requests are also gated by nRST so an in-flight access drops the moment reset asserts.
   assign run     = (state_q == RUN) & nRST;
   assign memreq  = mem_dREN | mem_dWEN;
   assign advance = run & ihit & (~memreq | dhit | served_q);
   assign hazard  = ex_dREN & (ex_wsel != 5'd0) &
                    ((ex_wsel == dec_rs) | (dec_uses_rt & (ex_wsel == dec_rt)));

   // A taken branch squashes the decode instruction, so its hazard is not a stall.
   assign stall_inc = run & (~advance | (~mem_branch_taken & hazard));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= RUN;
         served_q <= 1'b0;
         halt_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         served_q <= served_d;
         halt_q   <= halt_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == RUN && advance && mem_halt) state_d = HALTED;
   end

   always_comb begin
      served_d = served_q;
      if (advance)   served_d = 1'b0;
      else if (dhit) served_d = 1'b1;
      halt_d = halt_q | (advance & mem_halt);
      cnt_d  = cnt_q;
      if (stall_inc && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
   end

   always_comb begin
      pc_en         = 1'b0;
      fetch_en      = 1'b0;
      decode_en     = 1'b0;
      execute_en    = 1'b0;
      mem_en        = 1'b0;
      fetch_flush   = 1'b0;
      decode_flush  = 1'b0;
      execute_flush = 1'b0;
      if (advance) begin
         if (mem_branch_taken) begin
            {pc_en, fetch_en, decode_en, execute_en, mem_en} = 5'b11111;
            {fetch_flush, decode_flush, execute_flush}       = 3'b111;
         end else if (hazard) begin
            decode_en    = 1'b1;
            decode_flush = 1'b1;
            execute_en   = 1'b1;
            mem_en       = 1'b1;
         end else begin
            {pc_en, fetch_en, decode_en, execute_en, mem_en} = 5'b11111;
         end
      end
      imemREN = run;
      dmemWEN = run & mem_dWEN & ~served_q;
      dmemREN = run & mem_dREN & ~mem_dWEN & ~served_q;
   end

   assign halt        = halt_q;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed test-plan steps followed by random traffic, all checked against a
// cycle-level reference model of the sequencing rules.
module tb_pipeline_control;
   localparam int CW = 4;

   logic CLK = 1'b0, nRST = 1'b0;
   logic ihit, dhit, dec_uses_rt, ex_dREN, mem_dREN, mem_dWEN, mem_branch_taken, mem_halt;
   logic [4:0] dec_rs, dec_rt, ex_wsel;
   logic pc_en, fetch_en, decode_en, execute_en, mem_en;
   logic fetch_flush, decode_flush, execute_flush, imemREN, dmemREN, dmemWEN, halt;
   logic [CW-1:0] stall_count;

   int checks = 0, errors = 0;

   // reference model state
   bit m_halted, m_served;
   int m_cnt;

   pipeline_control #(.CNT_W(CW)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dec_rs(dec_rs), .dec_rt(dec_rt),
      .dec_uses_rt(dec_uses_rt), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .mem_dREN(mem_dREN),
      .mem_dWEN(mem_dWEN), .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt),
      .pc_en(pc_en), .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
      .mem_en(mem_en), .fetch_flush(fetch_flush), .decode_flush(decode_flush),
      .execute_flush(execute_flush), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .halt(halt), .stall_count(stall_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_run();
      return !m_halted && nRST === 1'b1;
   endfunction

   function automatic bit m_adv();
      bit data_ok = !(mem_dREN || mem_dWEN) || dhit || m_served;
      return m_run() && ihit && data_ok;
   endfunction

   function automatic bit m_haz();
      if (!ex_dREN || ex_wsel == 0) return 0;
      return ex_wsel == dec_rs || (dec_uses_rt && ex_wsel == dec_rt);
   endfunction

   // {pc,fen,den,een,men,ff,df,ef,imem,dren,dwen,halt}
   function automatic logic [11:0] m_outs();
      bit [4:0] en = 0;
      bit [2:0] fl = 0;
      bit imem = m_run();
      bit dw = m_run() && mem_dWEN && !m_served;
      bit dr = m_run() && mem_dREN && !mem_dWEN && !m_served;
      if (m_adv()) begin
         if (mem_branch_taken) begin en = 5'b11111; fl = 3'b111; end
         else if (m_haz())     begin en = 5'b00111; fl = 3'b010; end
         else                        en = 5'b11111;
      end
      return {en, fl, imem, dr, dw, m_halted};
   endfunction

   task automatic check_now(input string tag);
      chk({tag, "_outs"}, 32'({pc_en, fetch_en, decode_en, execute_en, mem_en, fetch_flush,
          decode_flush, execute_flush, imemREN, dmemREN, dmemWEN, halt}), 32'(m_outs()));
      chk({tag, "_cnt"}, 32'(stall_count), 32'(m_cnt));
   endtask

   task automatic model_edge();
      bit adv = m_adv();
      if (m_run() && (!adv || (!mem_branch_taken && m_haz())) && m_cnt < (1 << CW) - 1) m_cnt++;
      if (adv) begin
         m_served = 0;
         if (mem_halt) m_halted = 1;
      end else if (dhit) m_served = 1;
   endtask

   task automatic tick(input string tag);
      @(negedge CLK);
      check_now(tag);
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic idle();
      {ihit, dhit, dec_uses_rt, ex_dREN, mem_dREN, mem_dWEN, mem_branch_taken, mem_halt} = '0;
      dec_rs = 0; dec_rt = 0; ex_wsel = 0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      m_halted = 0; m_served = 0; m_cnt = 0;
      #2;
      check_now("reset");
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      idle();
      @(posedge CLK); #1;
      do_reset();

      // 1: free-running fetch
      ihit = 1;
      tick("t1");
      chk("t1_cnt_zero", 32'(stall_count), 0);

      // 2: load waits three cycles on dhit
      do_reset(); idle();
      mem_dREN = 1; ihit = 1;
      repeat (3) tick("t2_wait");
      dhit = 1;
      tick("t2_hit");
      chk("t2_cnt3", 32'(stall_count), 3);

      // 3: store completes before ihit; served suppresses a second strobe
      do_reset(); idle();
      mem_dWEN = 1; dhit = 1;
      tick("t3_dhit");
      dhit = 0;
      tick("t3_served");
      chk("t3_no_restrobe", 32'(dmemWEN), 0);
      ihit = 1;
      tick("t3_adv");

      // both requests: store wins
      mem_dREN = 1;
      tick("t3_both");

      // 4: load-use, then the same with r0 as destination
      idle(); ihit = 1; ex_dREN = 1; ex_wsel = 5; dec_rs = 5;
      tick("t4_haz");
      dec_rs = 1; dec_rt = 5; dec_uses_rt = 1;
      tick("t4_haz_rt");
      dec_uses_rt = 0;
      tick("t4_rt_unused");
      ex_wsel = 0; dec_rs = 0;
      tick("t4_r0");

      // 5: branch overrides load-use
      ex_wsel = 5; dec_rs = 5; mem_branch_taken = 1;
      tick("t5_branch");

      // 6: halt with simultaneous branch, then absorbing state
      mem_halt = 1;
      tick("t6_halt");
      chk("t6_halt_set", 32'(halt), 1);
      idle(); ihit = 1; mem_dREN = 1; dhit = 1;
      repeat (10) tick("t6_halted");
      do_reset();
      chk("t6_halt_clr", 32'(halt), 0);
      tick("t6_run");

      // counter saturation
      idle();
      repeat (20) tick("sat");
      chk("sat_max", 32'(stall_count), (1 << CW) - 1);

      // reset during an outstanding load drops the strobe at once
      idle(); mem_dREN = 1;
      #2;
      chk("mid_req", 32'(dmemREN), 1);
      nRST = 1'b0;
      #1;
      chk("mid_drop", 32'(dmemREN), 0);
      @(posedge CLK); #1;
      do_reset();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         ihit             = ($urandom_range(3) != 0);
         dhit             = $urandom_range(1);
         mem_dREN         = ($urandom_range(3) == 0);
         mem_dWEN         = ($urandom_range(3) == 0);
         mem_branch_taken = ($urandom_range(7) == 0);
         mem_halt         = ($urandom_range(59) == 0);
         ex_dREN          = $urandom_range(1);
         dec_uses_rt      = $urandom_range(1);
         ex_wsel          = 5'($urandom_range(3));
         dec_rs           = 5'($urandom_range(3));
         dec_rt           = 5'($urandom_range(3));
         tick("rnd");
         if ($urandom_range(149) == 0 || (m_halted && $urandom_range(15) == 0)) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
